// File: rtl/rob_commit.sv
// Retires up to two in-order ROB head entries per cycle. Commit strobes are combinational,
// and freelist/arch-RAT/difftest outputs follow one cycle later. commit_block or flush_vld stalls retirement.
module rob_commit #(
  parameter int ROB_DEPTH  = 64,
  parameter int PTR_W      = 6,
  parameter int PC_W       = 64,
  parameter int LREG_W     = 5,
  parameter int PREG_W     = 6,
  parameter int HANG_LIMIT = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            head_valid,
  input  logic [1:0]            head_complete,
  input  logic [1:0]            head_need_to_wb,
  input  logic [1:0]            head_skip,
  input  logic [2*PC_W-1:0]     head_pc,
  input  logic [63:0]           head_instr,
  input  logic [2*LREG_W-1:0]   head_lrd,
  input  logic [2*PREG_W-1:0]   head_prd,
  input  logic [2*PREG_W-1:0]   head_old_prd,
  input  logic                  commit_block,
  input  logic                  flush_vld,
  output logic [1:0]            commit_vld,
  output logic [PTR_W:0]        head_ptr,
  output logic [1:0]            free_vld,
  output logic [2*PREG_W-1:0]   free_preg,
  output logic [1:0]            arat_vld,
  output logic [2*LREG_W-1:0]   arat_lrd,
  output logic [2*PREG_W-1:0]   arat_prd,
  output logic [2*PC_W-1:0]     dbg_commit_pc,
  output logic [1:0]            dbg_commit_skip,
  output logic [63:0]           instret,
  output logic                  hang
);

  localparam int WD_W = $clog2(HANG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(HANG_LIMIT);

  logic [1:0]      rdy;
  logic [1:0]      eff;
  logic [1:0]      n_commit;
  logic            stall;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_nxt;
  logic            unused_instr;

  // The instruction word is carried only for trace tooling outside this block.
  assign unused_instr = ^head_instr;

  assign rdy           = head_valid & head_complete;
  assign commit_vld[0] = rdy[0] & ~commit_block & ~flush_vld;
  assign commit_vld[1] = commit_vld[0] & rdy[1];
  assign n_commit      = {1'b0, commit_vld[0]} + {1'b0, commit_vld[1]};

  for (genvar i = 0; i < 2; i++) begin : g_eff
    assign eff[i] = commit_vld[i] & head_need_to_wb[i] &
                    (head_lrd[i*LREG_W +: LREG_W] != '0);
  end

  // Ptr carries a wrap bit above the index, so plain addition toggles it on wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
    end else if (flush_vld) begin
      head_ptr <= '0;
    end else begin
      head_ptr <= head_ptr + (PTR_W+1)'(n_commit);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instret <= '0;
    end else begin
      instret <= instret + 64'(n_commit);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      free_vld <= '0;
      arat_vld <= '0;
    end else if (flush_vld) begin
      free_vld <= '0;
      arat_vld <= '0;
    end else begin
      free_vld <= eff;
      arat_vld <= eff;
    end
  end

  // Payload registers hold their last committed values between commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      free_preg       <= '0;
      arat_lrd        <= '0;
      arat_prd        <= '0;
      dbg_commit_pc   <= '0;
      dbg_commit_skip <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (commit_vld[i]) begin
          free_preg[i*PREG_W +: PREG_W] <= head_old_prd[i*PREG_W +: PREG_W];
          arat_lrd[i*LREG_W +: LREG_W]  <= head_lrd[i*LREG_W +: LREG_W];
          arat_prd[i*PREG_W +: PREG_W]  <= head_prd[i*PREG_W +: PREG_W];
          dbg_commit_pc[i*PC_W +: PC_W] <= head_pc[i*PC_W +: PC_W];
          dbg_commit_skip[i]            <= head_skip[i];
        end
      end
    end
  end

  assign stall = head_valid[0] & ~head_complete[0];

  always_comb begin
    wd_nxt = '0;
    if (!flush_vld && stall) begin
      wd_nxt = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      hang   <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      hang   <= hang | (wd_nxt == WD_MAX);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: vector table, directed corner sequences and random traffic vs a queue-free model.
module tb_rob_commit;
  localparam int HANG = 4096;

  logic        clock;
  logic        reset_n;
  logic [1:0]  v, c, wb, sk;
  logic [4:0]  lrd [2];
  logic [5:0]  oprd [2];
  logic [5:0]  prd [2];
  logic [63:0] pc [2];
  logic [31:0] ins [2];
  logic        blk, fl;

  logic [1:0]   commit_vld, free_vld, arat_vld, dbg_commit_skip;
  logic [6:0]   head_ptr;
  logic [11:0]  free_preg, arat_prd;
  logic [9:0]   arat_lrd;
  logic [127:0] dbg_commit_pc;
  logic [63:0]  instret;
  logic         hang;

  rob_commit dut (
    .clock(clock), .reset_n(reset_n),
    .head_valid(v), .head_complete(c), .head_need_to_wb(wb), .head_skip(sk),
    .head_pc({pc[1], pc[0]}), .head_instr({ins[1], ins[0]}),
    .head_lrd({lrd[1], lrd[0]}), .head_prd({prd[1], prd[0]}),
    .head_old_prd({oprd[1], oprd[0]}),
    .commit_block(blk), .flush_vld(fl),
    .commit_vld(commit_vld), .head_ptr(head_ptr),
    .free_vld(free_vld), .free_preg(free_preg),
    .arat_vld(arat_vld), .arat_lrd(arat_lrd), .arat_prd(arat_prd),
    .dbg_commit_pc(dbg_commit_pc), .dbg_commit_skip(dbg_commit_skip),
    .instret(instret), .hang(hang)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int          m_ptr;
  logic [63:0] m_instret;
  logic [1:0]  m_fv, m_av, m_sk;
  logic [5:0]  m_fp [2];
  logic [5:0]  m_ap [2];
  logic [4:0]  m_al [2];
  logic [63:0] m_pc [2];
  int          m_wd;
  bit          m_hang;

  typedef struct {
    logic [1:0] v, c, wb;
    logic [4:0] l0, l1;
    logic [5:0] o0, o1, p0, p1;
    logic       blk, fl;
    logic [1:0] cv, fv;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_instret = '0; m_fv = '0; m_av = '0; m_sk = '0;
    m_wd = 0; m_hang = 0;
    for (int i = 0; i < 2; i++) begin
      m_fp[i] = '0; m_ap[i] = '0; m_al[i] = '0; m_pc[i] = '0;
    end
  endtask

  task automatic set_in(input logic [1:0] vv, cc, ww, input logic [4:0] l0, l1,
                        input logic [5:0] o0, o1, p0, p1, input logic b, f);
    v = vv; c = cc; wb = ww; blk = b; fl = f;
    lrd[0] = l0; lrd[1] = l1; oprd[0] = o0; oprd[1] = o1; prd[0] = p0; prd[1] = p1;
    sk = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      pc[i]  = {$urandom, $urandom};
      ins[i] = $urandom;
    end
  endtask

  // Called just after a posedge check point; inputs are already applied.
  task automatic cycle(input bit use_tbl, input logic [1:0] tcv, input logic [1:0] tfv);
    int n;
    logic [1:0] ecv;
    #2;
    n = 0;
    if (!blk && !fl && v[0] && c[0]) begin
      n = 1;
      if (v[1] && c[1]) n = 2;
    end
    ecv = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    chk("commit_vld", commit_vld, ecv);
    if (use_tbl) chk("tbl_commit_vld", commit_vld, tcv);
    if (fl) begin
      m_ptr = 0; m_wd = 0; m_fv = '0; m_av = '0;
    end else begin
      m_ptr = (m_ptr + n) % 128;
      for (int i = 0; i < 2; i++) begin
        if (i < n) begin
          m_fv[i] = wb[i] && (lrd[i] != 0);
          m_av[i] = m_fv[i];
          m_fp[i] = oprd[i]; m_al[i] = lrd[i]; m_ap[i] = prd[i];
          m_pc[i] = pc[i]; m_sk[i] = sk[i];
        end else begin
          m_fv[i] = 1'b0; m_av[i] = 1'b0;
        end
      end
      if (v[0] && !c[0]) m_wd = (m_wd < HANG) ? m_wd + 1 : m_wd;
      else m_wd = 0;
    end
    if (m_wd >= HANG) m_hang = 1;
    m_instret = m_instret + 64'(n);
    @(posedge clock); #1;
    chk("head_ptr", 64'(head_ptr), 64'(m_ptr));
    chk("instret", instret, m_instret);
    chk("free_vld", 64'(free_vld), 64'(m_fv));
    chk("arat_vld", 64'(arat_vld), 64'(m_av));
    chk("hang", 64'(hang), 64'(m_hang));
    chk("dbg_skip", 64'(dbg_commit_skip), 64'(m_sk));
    for (int i = 0; i < 2; i++) begin
      chk("dbg_pc", dbg_commit_pc[i*64 +: 64], m_pc[i]);
      if (m_fv[i]) chk("free_preg", 64'(free_preg[i*6 +: 6]), 64'(m_fp[i]));
      if (m_av[i]) begin
        chk("arat_lrd", 64'(arat_lrd[i*5 +: 5]), 64'(m_al[i]));
        chk("arat_prd", 64'(arat_prd[i*6 +: 6]), 64'(m_ap[i]));
      end
    end
    if (use_tbl) chk("tbl_free_vld", 64'(free_vld), 64'(tfv));
  endtask

  initial begin
    //              v      c      wb     l0 l1 o0  o1  p0  p1  blk fl  cv     fv
    tbl[0] = '{2'b11, 2'b11, 2'b11, 3, 7, 10, 11, 20, 21, 0, 0, 2'b11, 2'b11};
    tbl[1] = '{2'b11, 2'b10, 2'b11, 1, 2, 12, 13, 22, 23, 0, 0, 2'b00, 2'b00};
    tbl[2] = '{2'b11, 2'b11, 2'b11, 0, 5, 14, 15, 24, 25, 0, 0, 2'b11, 2'b10};
    tbl[3] = '{2'b11, 2'b11, 2'b11, 6, 8, 16, 17, 26, 27, 1, 0, 2'b00, 2'b00};
    tbl[4] = '{2'b11, 2'b11, 2'b11, 6, 8, 16, 17, 26, 27, 0, 1, 2'b00, 2'b00};
    tbl[5] = '{2'b01, 2'b01, 2'b01, 4, 9, 30, 31, 40, 41, 0, 0, 2'b01, 2'b01};
    tbl[6] = '{2'b11, 2'b11, 2'b01, 4, 9, 32, 33, 42, 43, 0, 0, 2'b11, 2'b01};
    tbl[7] = '{2'b11, 2'b11, 2'b11, 9, 9, 34, 35, 44, 45, 0, 0, 2'b11, 2'b11};
    tbl[8] = '{2'b11, 2'b01, 2'b11, 2, 3, 36, 37, 46, 47, 0, 0, 2'b01, 2'b01};
    tbl[9] = '{2'b00, 2'b11, 2'b11, 2, 3, 38, 39, 48, 49, 0, 0, 2'b00, 2'b00};

    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_head_ptr", 64'(head_ptr), 64'd0);
    chk("rst_commit_vld", 64'(commit_vld), 64'd0);
    chk("rst_free_vld", 64'(free_vld), 64'd0);
    chk("rst_arat_vld", 64'(arat_vld), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_hang", 64'(hang), 64'd0);
    chk("rst_dbg_pc", dbg_commit_pc[63:0], 64'd0);
    chk("rst_free_preg", 64'(free_preg), 64'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      set_in(tbl[k].v, tbl[k].c, tbl[k].wb, tbl[k].l0, tbl[k].l1,
             tbl[k].o0, tbl[k].o1, tbl[k].p0, tbl[k].p1, tbl[k].blk, tbl[k].fl);
      cycle(1'b1, tbl[k].cv, tbl[k].fv);
    end

    for (int k = 0; k < 400; k++) begin
      set_in(2'($urandom), ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom), 2'($urandom),
             5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 5'($urandom),
             6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      cycle(1'b0, 2'b00, 2'b00);
    end

    // Walk the head up to index 63 (wrap bit clear), then retire two across the boundary.
    for (int k = 0; k < 130 && m_ptr != 63; k++) begin
      set_in(2'b01, 2'b01, 2'b01, 1, 2, 3, 4, 5, 6, 0, 0);
      cycle(1'b0, 2'b00, 2'b00);
    end
    chk("wrap_pre_ptr", 64'(head_ptr), 64'd63);
    set_in(2'b11, 2'b11, 2'b11, 1, 2, 3, 4, 5, 6, 0, 0);
    cycle(1'b0, 2'b00, 2'b00);
    chk("wrap_ptr", 64'(head_ptr), 64'h41);

    for (int k = 0; k < HANG - 1; k++) begin
      set_in(2'b01, 2'b00, 2'b00, 1, 2, 3, 4, 5, 6, 0, 0);
      cycle(1'b0, 2'b00, 2'b00);
    end
    chk("hang_before_limit", 64'(hang), 64'd0);
    set_in(2'b01, 2'b00, 2'b00, 1, 2, 3, 4, 5, 6, 0, 0);
    cycle(1'b0, 2'b00, 2'b00);
    chk("hang_at_limit", 64'(hang), 64'd1);
    set_in(2'b01, 2'b01, 2'b01, 1, 2, 3, 4, 5, 6, 0, 0);
    cycle(1'b0, 2'b00, 2'b00);
    chk("hang_sticky", 64'(hang), 64'd1);

    // Reset asserted mid-run while both heads are ready.
    set_in(2'b11, 2'b11, 2'b11, 3, 7, 10, 11, 20, 21, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_head_ptr", 64'(head_ptr), 64'd0);
    chk("mid_rst_instret", instret, 64'd0);
    chk("mid_rst_free_vld", 64'(free_vld), 64'd0);
    chk("mid_rst_hang", 64'(hang), 64'd0);
    @(posedge clock); #1;
    chk("mid_rst_hold_ptr", 64'(head_ptr), 64'd0);
    chk("mid_rst_hold_instret", instret, 64'd0);
    chk("mid_rst_hold_free_vld", 64'(free_vld), 64'd0);
    v = 2'b00;
    #1;
    chk("mid_rst_commit_vld", 64'(commit_vld), 64'd0);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 2'b11, 2'b11, 5'(k + 1), 5'(k + 2), 6'(k), 6'(k + 8), 6'(k + 16), 6'(k + 24), 0, 0);
      cycle(1'b0, 2'b00, 2'b00);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
